fifo_rd_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_rd_packer.sv | 130 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side packer
package fifo_pkg;

    // Packer control states: collecting entries, or presenting a word downstream
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Widest keep mask the helper can produce; callers truncate to their lane count
    localparam int KEEP_MAX = 64;

    // Mask with the low `count` lanes set, lane 0 being the first entry popped
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int count);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < count) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries and packs them into wide words with flush
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             rclk,
    input  logic                             rrst,
    input  logic                             rempty,
    input  logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rinc,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_last,
    output logic [15:0]                      word_cnt
);

    // fill_cnt must hold PACK_RATIO itself plus one pending pop on top of it
    localparam int CW = $clog2(PACK_RATIO) + 1;
    localparam int LW = CW - 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

    pack_state_t                                 state_q, state_d;
    logic [CW-1:0]                               fill_cnt_q, fill_cnt_d;
    logic                                        pend_q, pend_d;
    logic                                        flush_req_q, flush_req_d;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]       acc_q, acc_d;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [PACK_RATIO-1:0]                       out_keep_q, out_keep_d;
    logic                                        out_last_q, out_last_d;
    logic [15:0]                                 word_cnt_q, word_cnt_d;

    logic [CW-1:0]                               cap_cnt;
    logic [PACK_RATIO-1:0]                       part_mask;

    // Pop only while collecting, with room for the in-flight entry, and never
    // while a flush is waiting so the partial word reflects exactly what was popped
    assign rinc = !rrst && (state_q == FILL) && !rempty && !flush_req_q &&
                  ((fill_cnt_q + CW'(pend_q)) < FULL_CNT);

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;

    // Next-state: capture popped data, close full or flushed words, retire on handshake
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        pend_d      = rinc;
        flush_req_d = flush_req_q | flush;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;
        cap_cnt     = fill_cnt_q + CW'(1);
        part_mask   = PACK_RATIO'(keep_mask(int'(fill_cnt_q)));

        case (state_q)
            FILL: begin
                if (pend_q) begin
                    acc_d[fill_cnt_q[LW-1:0]] = rdata;
                    fill_cnt_d = cap_cnt;
                    if (cap_cnt == FULL_CNT) begin
                        out_data_d = acc_d;
                        out_keep_d = '1;
                        out_last_d = flush_req_q;
                        state_d    = HOLD;
                        // A flush that was already pending is satisfied by this word
                        if (flush_req_q) begin
                            flush_req_d = flush;
                        end
                    end
                end else if (flush_req_q) begin
                    flush_req_d = flush;
                    if (fill_cnt_q != '0) begin
                        for (int i = 0; i < PACK_RATIO; i++) begin
                            out_data_d[i] = part_mask[i] ? acc_q[i] : '0;
                        end
                        out_keep_d = part_mask;
                        out_last_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State register; reset discards any partially collected word and in-flight pop
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench for fifo_rd_packer against a FIFO read-port model
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int WW = DW * PR;
    localparam int LIMIT = 3000;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic [PR-1:0] out_keep;
    logic          out_last;
    logic [15:0]   word_cnt;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .word_cnt(word_cnt)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [WW-1:0] data;
        logic [PR-1:0] keep;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] model_acc[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            ready_mode = 1;
    logic          pop_s = 1'b0;
    event          fifo_changed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO read-port model ----------------
    always @(negedge rclk) pop_s = rinc;

    always @(posedge rclk) begin
        if (pop_s && fifo_q.size() > 0) begin
            rdata <= fifo_q.pop_front();
            -> fifo_changed;
        end
    end

    always @(fifo_changed) rempty = (fifo_q.size() == 0);

    // ---------------- downstream ready driver ----------------
    always @(posedge rclk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // ---------------- reference model ----------------
    function automatic void model_emit(input bit last);
        word_t w;
        w.data = '0;
        for (int i = 0; i < model_acc.size(); i++) begin
            w.data = w.data | (WW'(model_acc[i]) << (DW * i));
        end
        w.keep = PR'((32'd1 << model_acc.size()) - 32'd1);
        w.last = last;
        exp_q.push_back(w);
        model_acc.delete();
    endfunction

    function automatic void model_flush();
        if (model_acc.size() > 0) model_emit(1'b1);
    endfunction

    task automatic push(input logic [DW-1:0] v, input bit last_on_full);
        fifo_q.push_back(v);
        -> fifo_changed;
        model_acc.push_back(v);
        if (model_acc.size() == PR) model_emit(last_on_full);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int    xfer_cnt = 0;
    logic  hold_prev = 1'b0;
    word_t prev_w;
    word_t mon_w;

    always @(negedge rclk) begin
        if (rrst) begin
            xfer_cnt  = 0;
            hold_prev = 1'b0;
        end else begin
            if (rinc) chk("pop_while_empty", 64'(rempty), 64'd0);
            if (out_valid) chk("rinc_in_hold", 64'(rinc), 64'd0);
            if (hold_prev) begin
                chk("valid_held", 64'(out_valid), 64'd1);
                chk("data_stable", 64'(out_data), 64'(prev_w.data));
                chk("keep_stable", 64'(out_keep), 64'(prev_w.keep));
                chk("last_stable", 64'(out_last), 64'(prev_w.last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got data 0x%0h, none expected", out_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(mon_w.data));
                    chk("out_keep", 64'(out_keep), 64'(mon_w.keep));
                    chk("out_last", 64'(out_last), 64'(mon_w.last));
                end
                chk("word_cnt", 64'(word_cnt), 64'(xfer_cnt));
                xfer_cnt = (xfer_cnt + 1) & 16'hffff;
            end
            hold_prev   = out_valid && !out_ready;
            prev_w.data = out_data;
            prev_w.keep = out_keep;
            prev_w.last = out_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        model_flush();
        step();
        flush = 1'b0;
    endtask

    task automatic wait_fifo_empty(input string name);
        int n = 0;
        while (fifo_q.size() != 0 && n < LIMIT) begin
            step();
            n++;
        end
        chk({name, "_fifo_drain"}, 64'(n < LIMIT), 64'd1);
        repeat (3) step();
    endtask

    task automatic wait_all_out(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid || fifo_q.size() != 0) && n < LIMIT) begin
            step();
            n++;
        end
        chk({name, "_words_out"}, 64'(n < LIMIT), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk({name, "_valid_seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge rclk);
            chk(name, 64'(out_valid), 64'd0);
        end
        step();
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin
        int k;

        // Reset state
        repeat (2) @(negedge rclk);
        chk("rst_rinc", 64'(rinc), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_keep", 64'(out_keep), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        step();
        rrst = 1'b0;
        step();

        // Basic pack and first-word latency with ready high
        ready_mode = 1;
        step();
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        #1;
        chk("first_rinc", 64'(rinc), 64'd1);
        k = 0;
        @(negedge rclk);
        while (!out_valid && k < 20) begin
            k++;
            @(negedge rclk);
        end
        chk("valid_latency", 64'(k), 64'(PR + 1));
        chk("basic_data", 64'(out_data), 64'h44332211);
        @(negedge rclk);
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("word_cnt_basic", 64'(word_cnt), 64'd1);
        step();
        wait_all_out("basic");

        // Backpressure: held word stable, no pops while holding
        ready_mode = 0;
        step();
        for (int i = 1; i <= 8; i++) push(8'(i), 0);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            chk("bp_held_data", 64'(out_data), 64'h04030201);
            chk("bp_rinc_low", 64'(rinc), 64'd0);
        end
        step();
        ready_mode = 1;
        wait_all_out("bp");

        // Partial flush and its latency
        push(8'hAA, 0); push(8'hBB, 0);
        wait_fifo_empty("partial");
        pulse_flush();
        k = 1;
        @(negedge rclk);
        while (!out_valid && k < 3) begin
            k++;
            @(negedge rclk);
        end
        chk("flush_latency", 64'(out_valid && k <= 2), 64'd1);
        chk("partial_data", 64'(out_data), 64'h0000BBAA);
        step();
        wait_all_out("partial");

        // Flush with nothing accumulated emits nothing and does not block later pops
        pulse_flush();
        check_idle("empty_flush_no_word", 6);
        for (int i = 0; i < PR; i++) push(8'h50 + 8'(i), 0);
        wait_all_out("after_empty_flush");

        // Flush while holding: word untouched, flush dissolves on return to FILL
        ready_mode = 0;
        step();
        for (int i = 1; i <= PR; i++) push(8'hC0 + 8'(i), 0);
        wait_valid("hold_flush");
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            chk("hold_flush_data", 64'(out_data), 64'hC4C3C2C1);
            chk("hold_flush_keep", 64'(out_keep), 64'hF);
            chk("hold_flush_last", 64'(out_last), 64'd0);
        end
        step();
        ready_mode = 1;
        wait_all_out("hold_flush");
        check_idle("hold_flush_no_extra", 6);
        for (int i = 0; i < PR; i++) push(8'h60 + 8'(i), 0);
        wait_all_out("after_hold_flush");

        // Flush coincident with the last pop of a full word
        push(8'hD1, 0); push(8'hD2, 0); push(8'hD3, 0); push(8'hD4, 1);
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_all_out("flush_full");

        // Reset mid-fill discards the partial word
        push(8'hE1, 0); push(8'hE2, 0); push(8'hE3, 0);
        wait_fifo_empty("rst_mid");
        rrst = 1'b1;
        model_acc.delete();
        @(negedge rclk);
        chk("mid_rst_rinc", 64'(rinc), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_keep", 64'(out_keep), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
        step();
        rrst = 1'b0;
        push(8'hF1, 0); push(8'hF2, 0); push(8'hF3, 0); push(8'hF4, 0);
        wait_all_out("rst_mid");

        // Randomized bursts, gaps, flushes and downstream stalls
        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            k = $urandom_range(1, 9);
            for (int j = 0; j < k; j++) begin
                push(8'($urandom), 0);
                repeat ($urandom_range(0, 2)) step();
            end
            step();
            if ($urandom_range(0, 1) == 1) begin
                wait_fifo_empty("rand");
                pulse_flush();
            end
        end
        ready_mode = 1;
        wait_fifo_empty("final");
        pulse_flush();
        wait_all_out("final");
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
